// File: rtl/spi_ram_master_ctrl_pkg.sv
// Shared types for the SPI RAM master sequencer: frame commands, FSM states and widths.
package spi_ram_master_ctrl_pkg;

   localparam int MEM_WIDTH = 8;
   localparam int CMD_WIDTH = 2;

   // The command MSB is the slave's read/write decision bit; the LSB selects the data frame.
   typedef enum logic [CMD_WIDTH-1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } spi_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      SHIFT,
      WAIT,
      CAPTURE,
      DESEL,
      DONE
   } spi_mst_state_e;

   function automatic spi_cmd_e frame_cmd(input logic rd, input logic data_frame);
      return spi_cmd_e'({rd, data_frame});
   endfunction

endpackage

// File: rtl/spi_ram_master_ctrl_if.sv
// Host request/response bus of the SPI RAM master; master = host side, slave = controller side.
interface spi_ram_master_ctrl_if #(
   parameter int MEM_WIDTH = spi_ram_master_ctrl_pkg::MEM_WIDTH
);

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_rd;
   logic [MEM_WIDTH-1:0] req_addr;
   logic [MEM_WIDTH-1:0] req_wdata;
   logic                 rsp_valid;
   logic [MEM_WIDTH-1:0] rsp_rdata;
   logic                 busy;

   modport master (
      output req_valid, req_rd, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_rd, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy
   );

endinterface

// File: rtl/spi_ram_master_ctrl_frame_shifter.sv
// Serialiser for one {cmd, payload} frame onto MOSI plus MISO byte capture, strobed by the master FSM.
module spi_ram_master_ctrl_frame_shifter
   import spi_ram_master_ctrl_pkg::*;
#(
   parameter int MEM_WIDTH = spi_ram_master_ctrl_pkg::MEM_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load,
   input  logic [MEM_WIDTH+CMD_WIDTH-1:0] word,
   input  logic                           shift,
   input  logic                           capture,
   input  logic                           miso,
   output logic                           mosi,
   output logic                           shift_last,
   output logic                           cap_last,
   output logic [MEM_WIDTH-1:0]           cap_data
);

   localparam int FW    = MEM_WIDTH + CMD_WIDTH;
   localparam int BIT_W = $clog2(FW + 1);
   localparam int CAP_W = $clog2(MEM_WIDTH);
   localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(MEM_WIDTH - 1);

   logic [FW-1:0]        sreg;
   logic [BIT_W-1:0]     bit_cnt;
   logic [CAP_W-1:0]     cap_cnt;
   logic                 mosi_q;
   logic [MEM_WIDTH-1:0] cap_q;

   // Load presents the command MSB on MOSI for the select cycle; the counter then
   // reads FW-1..0 while bit FW-1..0 is on the wire, and MOSI drops to 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= '0;
         bit_cnt <= '0;
         cap_cnt <= '0;
         mosi_q  <= 1'b0;
         cap_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values, so
         // the shift register and MOSI update together without ordering hazards.
         if (load) begin
            sreg    <= word;
            bit_cnt <= BIT_W'(FW);
            mosi_q  <= word[FW-1];
            cap_cnt <= '0;
         end else if (shift) begin
            sreg    <= {sreg[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
            mosi_q  <= sreg[FW-1];
         end else begin
            mosi_q  <= 1'b0;
         end
         if (capture) begin
            cap_q   <= {cap_q[MEM_WIDTH-2:0], miso};
            cap_cnt <= cap_cnt + 1'b1;
         end
      end
   end

   assign mosi       = mosi_q;
   assign shift_last = (bit_cnt == '0);
   assign cap_last   = (cap_cnt == CAP_LAST);
   assign cap_data   = cap_q;

endmodule

// File: rtl/spi_ram_master_ctrl.sv
// SPI RAM master sequencer: one host request becomes an address frame and a data frame on SS_n/MOSI.
// Optional build macro SPI_MASTER_ADDR_CACHE_EN skips the address frame when it repeats the last one.
module spi_ram_master_ctrl
   import spi_ram_master_ctrl_pkg::*;
#(
   parameter int MEM_WIDTH  = spi_ram_master_ctrl_pkg::MEM_WIDTH,
   parameter int RD_LATENCY = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_ram_master_ctrl_if.slave bus,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int FW    = MEM_WIDTH + CMD_WIDTH;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

   spi_mst_state_e       state;
   logic                 rd_q;
   logic                 data_phase;
   logic [MEM_WIDTH-1:0] addr_q;
   logic [MEM_WIDTH-1:0] wdata_q;
   logic [CNT_W-1:0]     cnt;
   logic                 req_ready_q;
   logic                 busy_q;
   logic                 rsp_valid_q;
   logic [MEM_WIDTH-1:0] rsp_rdata_q;
   logic                 ss_n_q;

   logic                 accept;
   logic                 gap_done;
   logic                 addr_hit;
   logic                 frame_rd;
   logic                 frame_data;
   logic [MEM_WIDTH-1:0] frame_payload;
   logic [FW-1:0]        frame_word;
   logic                 sh_load;
   logic                 sh_shift;
   logic                 sh_capture;
   logic                 sh_last;
   logic                 cap_last;
   logic [MEM_WIDTH-1:0] cap_data;

`ifdef SPI_MASTER_ADDR_CACHE_EN
   logic                 wr_cache_vld;
   logic                 rd_cache_vld;
   logic [MEM_WIDTH-1:0] wr_cache_addr;
   logic [MEM_WIDTH-1:0] rd_cache_addr;

   assign addr_hit = bus.req_rd ? (rd_cache_vld && (rd_cache_addr == bus.req_addr))
                                : (wr_cache_vld && (wr_cache_addr == bus.req_addr));
`else
   assign addr_hit = 1'b0;
`endif

   assign accept   = bus.req_valid && req_ready_q;
   assign gap_done = (state == DESEL) && (cnt == GAP_LAST);

   // The first frame is built straight from the bus at accept; the second from latched fields.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      frame_rd      = rd_q;
      frame_data    = 1'b1;
      frame_payload = '0;
      if (state == IDLE) begin
         frame_rd   = bus.req_rd;
         frame_data = addr_hit;
      end
      if (!frame_data) begin
         frame_payload = bus.req_addr;
      end else if (!frame_rd) begin
         frame_payload = (state == IDLE) ? bus.req_wdata : wdata_q;
      end
      frame_word = {frame_cmd(frame_rd, frame_data), frame_payload};
   end

   assign sh_load    = accept || (gap_done && !data_phase);
   assign sh_shift   = (state == SEL) || ((state == SHIFT) && !sh_last);
   assign sh_capture = (state == CAPTURE);

   spi_ram_master_ctrl_frame_shifter #(
      .MEM_WIDTH (MEM_WIDTH)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (sh_load),
      .word       (frame_word),
      .shift      (sh_shift),
      .capture    (sh_capture),
      .miso       (MISO),
      .mosi       (MOSI),
      .shift_last (sh_last),
      .cap_last   (cap_last),
      .cap_data   (cap_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the asynchronous reset releases SS_n in the very cycle rst_n falls, aborting any frame.
      if (!rst_n) begin
         state       <= IDLE;
         rd_q        <= 1'b0;
         data_phase  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         ss_n_q      <= 1'b1;
`ifdef SPI_MASTER_ADDR_CACHE_EN
         wr_cache_vld  <= 1'b0;
         rd_cache_vld  <= 1'b0;
         wr_cache_addr <= '0;
         rd_cache_addr <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  rd_q        <= bus.req_rd;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  data_phase  <= addr_hit;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  ss_n_q      <= 1'b0;
                  state       <= SEL;
               end
            end
            SEL: state <= SHIFT;
            SHIFT: begin
               if (sh_last) begin
                  cnt <= '0;
`ifdef SPI_MASTER_ADDR_CACHE_EN
                  if (!data_phase) begin
                     if (rd_q) begin
                        rd_cache_vld  <= 1'b1;
                        rd_cache_addr <= addr_q;
                     end else begin
                        wr_cache_vld  <= 1'b1;
                        wr_cache_addr <= addr_q;
                     end
                  end
`endif
                  if (data_phase && rd_q) begin
                     state <= (RD_LATENCY == 0) ? CAPTURE : WAIT;
                  end else begin
                     ss_n_q <= 1'b1;
                     state  <= DESEL;
                  end
               end
            end
            WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt   <= '0;
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               if (cap_last) begin
                  ss_n_q <= 1'b1;
                  state  <= DESEL;
               end
            end
            DESEL: begin
               if (gap_done) begin
                  cnt <= '0;
                  if (!data_phase) begin
                     data_phase <= 1'b1;
                     ss_n_q     <= 1'b0;
                     state      <= SEL;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rd_q ? cap_data : '0;
                     state       <= DONE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign SS_n          = ss_n_q;

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Scoreboard bench for spi_ram_master_ctrl: a transaction-level model predicts frames and responses,
// and a monitor acting as the SPI RAM slave decodes MOSI, answers on MISO and compares.
module tb_spi_ram_master_ctrl;

   localparam int MW   = 8;
   localparam int RL   = 2;
   localparam int GAP  = 1;
   localparam int FLEN = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic SS_n;
   logic MOSI;
   logic MISO  = 1'b0;

   spi_ram_master_ctrl_if #(.MEM_WIDTH(MW)) bus ();

   spi_ram_master_ctrl #(
      .MEM_WIDTH  (MW),
      .RD_LATENCY (RL),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .SS_n  (SS_n),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] rdata;
      int         lat;
   } rsp_t;

   int         checks    = 0;
   int         failures  = 0;
   rsp_t       rsp_q[$];
   logic [9:0] frame_q[$];
   int         acc_q[$];
   int         acc_log[$];
   logic [7:0] ref_mem [256];
   logic [7:0] slv_mem [256];
   bit         ref_cvld [2];
   logic [7:0] ref_caddr [2];
   bit         mon_en    = 1'b0;
   int         stray_rsp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: frames sent, response data and accept-to-response latency.
   task automatic issue(input bit rd, input logic [7:0] addr, input logic [7:0] wdata, output int lat);
      bit   hit = 1'b0;
      rsp_t r;
      int   n = 0;
`ifdef SPI_MASTER_ADDR_CACHE_EN
      hit = ref_cvld[rd] && (ref_caddr[rd] == addr);
      ref_cvld[rd]  = 1'b1;
      ref_caddr[rd] = addr;
`endif
      if (!hit) frame_q.push_back({rd, 1'b0, addr});
      frame_q.push_back({rd, 1'b1, (rd ? 8'h00 : wdata)});
      lat     = 1 + (hit ? 1 : 2) * (FLEN + GAP) + (rd ? RL + 8 : 0);
      r.rdata = rd ? ref_mem[addr] : 8'h00;
      r.lat   = lat;
      if (!rd) ref_mem[addr] = wdata;
      rsp_q.push_back(r);
      bus.req_rd    = rd;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 500) begin
            check("accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic release_bus();
      bus.req_valid = 1'b0;
   endtask

   // Monitor: response scoreboard plus SPI RAM slave decoding MOSI frames and driving MISO.
   initial begin : monitor
      bit         ss_prev  = 1'b1;
      bit         rd_frame = 1'b0;
      int         j        = 0;
      int         hi_cnt   = 0;
      int         frames   = 0;
      int         exp_len  = FLEN;
      int         a;
      logic [9:0] word     = '0;
      logic       pre      = 1'b0;
      logic [7:0] rbyte    = '0;
      logic [7:0] s_waddr  = '0;
      logic [7:0] s_raddr  = '0;
      rsp_t       r;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            ss_prev = 1'b1;
            frames  = 0;
            MISO    = 1'b0;
            if (bus.rsp_valid) stray_rsp++;
            continue;
         end
         check("ready_vs_busy", bus.req_ready, !bus.busy);
         if (bus.req_valid && bus.req_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
         end
         if (bus.rsp_valid) begin
            if (rsp_q.size() == 0 || acc_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               r = rsp_q.pop_front();
               a = acc_q.pop_front();
               check("rsp_rdata", bus.rsp_rdata, r.rdata);
               check("rsp_latency", cyc - a, r.lat);
            end
            frames = 0;
         end
         if (!SS_n) begin
            if (ss_prev) begin
               if (frames > 0) check("desel_gap", hi_cnt, GAP);
               j        = 0;
               word     = '0;
               rd_frame = 1'b0;
            end
            if (j == 0) pre = MOSI;
            else if (j < FLEN) word = {word[8:0], MOSI};
            if (j == FLEN - 1) begin
               if (frame_q.size() == 0) check("frame_unexpected", 1, 0);
               else check("frame_word", word, frame_q.pop_front());
               check("frame_prebit", pre, word[9]);
               rd_frame = (word[9:8] == 2'b11);
               exp_len  = rd_frame ? FLEN + RL + 8 : FLEN;
               case (word[9:8])
                  2'b00:   s_waddr = word[7:0];
                  2'b01:   slv_mem[s_waddr] = word[7:0];
                  2'b10:   s_raddr = word[7:0];
                  default: rbyte = slv_mem[s_raddr];
               endcase
            end
            if (rd_frame && j >= FLEN + RL && j < FLEN + RL + 8) MISO = rbyte[7 - (j - FLEN - RL)];
            else MISO = 1'b0;
            j++;
         end else begin
            if (!ss_prev) begin
               check("frame_len", j, exp_len);
               frames++;
               hi_cnt = 0;
            end
            hi_cnt++;
            check("mosi_idle", MOSI, 0);
            MISO = 1'b0;
         end
         ss_prev = SS_n;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int lat1;
      int lat2;
      int n;
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'($urandom);
         slv_mem[i] = ref_mem[i];
      end
      ref_mem[8'h0F] = 8'hC3;
      slv_mem[8'h0F] = 8'hC3;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ss_n", SS_n, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Abort a WR_ADDR frame mid-shift while MOSI carries a 1.
      bus.req_rd    = 1'b0;
      bus.req_addr  = 8'hA5;
      bus.req_wdata = 8'h3C;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_abort_ss_n", SS_n, 0);
      check("pre_abort_mosi", MOSI, 1);
      rst_n = 1'b0;
      #1;
      check("abort_ss_n", SS_n, 1);
      check("abort_mosi", MOSI, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_req_ready", bus.req_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      check("no_rsp_after_abort", stray_rsp, 0);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b0, 8'hA5, 8'h3C, lat);
      release_bus();
      issue(1'b1, 8'h0F, 8'h00, lat);
      release_bus();

      // req_valid stays high across two writes.
      n = acc_log.size();
      issue(1'b0, 8'h21, 8'h5A, lat1);
      issue(1'b0, 8'h22, 8'h6B, lat2);
      release_bus();

      issue(1'b0, 8'h10, 8'hAA, lat);
      release_bus();
      issue(1'b0, 8'h10, 8'hBB, lat);
      release_bus();
      issue(1'b1, 8'h10, 8'h00, lat);
      release_bus();

      for (int t = 0; t < 40; t++) begin
         issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), lat);
         release_bus();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      lat = 0;
      while (rsp_q.size() != 0 && lat < 3000) begin
         @(posedge clk);
         lat++;
      end
      repeat (5) @(posedge clk);
      check("drain_rsp", rsp_q.size(), 0);
      check("drain_frames", frame_q.size(), 0);
      if (acc_log.size() < n + 2) check("b2b_accepts", acc_log.size(), n + 2);
      else check("b2b_accept_spacing", acc_log[n+1] - acc_log[n], lat1 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_ram_master_ctrl.md
Name: spi_ram_master_ctrl

Overview:
Host-side SPI master sequencer for the SPI-slave + single-port RAM subsystem. Accepts one write or read request per handshake, breaks it into two SPI frames (address frame, then data frame), and drives SS_n/MOSI bit-serially. On reads it samples the returned byte from MISO. Sits between the host/bench bus and the SPI slave's SS_n/MOSI/MISO pins, on the same clk.

Parameters:
MEM_WIDTH, 8, data and address byte width (frame payload width)
RD_LATENCY, 2, clocks between the last MOSI bit of a read-data frame and the first MISO sample
GAP_CYCLES, 1, minimum clocks SS_n is held high between frames (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  host request present
req_ready  out  1  controller can accept a request
req_rd  in  1  1 = read, 0 = write
req_addr  in  MEM_WIDTH  target address
req_wdata  in  MEM_WIDTH  write data (ignored on reads)
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  MEM_WIDTH  read data, valid with rsp_valid (0 on writes)
busy  out  1  high from accept until rsp_valid cycle inclusive
SS_n  out  1  slave select, active low
MOSI  out  1  serial data to slave
MISO  in  1  serial data from slave

Behaviour:
- Reset, asynchronous via rst_n: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, FSM=IDLE, all counters 0. A reset mid-frame aborts the frame immediately; SS_n returns high in the same cycle.
- Accept on req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched at accept. Next cycle busy=1.
- Frame encoding: word[9:0] = {cmd[1:0], payload[7:0]}, cmd: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - Write: WR_ADDR(addr), then WR_DATA(wdata).
  - Read: RD_ADDR(addr), then RD_DATA(payload 8'h00).
- Per frame, in cycles after SEL entry:
  - cycle 0: SS_n=0, MOSI=cmd[1] (the slave's CHK_CMD read/write decision bit).
  - cycles 1..10: MOSI=word[9..0], MSB first.
- FSM states: IDLE -> SEL -> SHIFT (10 bits, bit counter 9 down to 0).
  - After SHIFT: DESEL, except RD_DATA frames, which go to WAIT.
  - WAIT: SS_n held 0 for RD_LATENCY cycles, then CAPTURE.
  - CAPTURE: 8 cycles with SS_n=0, shifts MISO into rdata MSB-first, then DESEL.
  - DESEL: SS_n=1, MOSI=0 for GAP_CYCLES cycles. If a second frame is pending -> SEL, else -> DONE.
  - DONE: one cycle. rsp_valid=1, rsp_rdata=captured byte (reads) or 0 (writes). Then IDLE.
- Total write transaction = 2×(11+GAP_CYCLES)+1 clocks from accept to rsp_valid with the optional feature off.
- A req_valid in DONE is not accepted; it is accepted earliest in the following IDLE cycle.
- MOSI is registered; SS_n is registered. No combinational path from MISO to any output.
- rsp_rdata holds its value until the next rsp_valid.

Optional Feature:
SPI_MASTER_ADDR_CACHE_EN: adds last-write-address and last-read-address registers, each with a valid bit cleared on reset.
- A request whose address equals the cached address for its direction skips the address frame and starts directly with WR_DATA or RD_DATA.
- Cache entry is updated after each completed address frame.
- Without the macro: the address frame is always sent, and there are no cache registers.

Decomposition:
- shared_pkg: spi_cmd_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), master FSM state enum spi_mst_state_e, and MEM_WIDTH.
- spi_frame_shifter is the one natural sub-module: it owns the MOSI shift register, the MISO capture register and the bit counters, with load/shift/capture strobes driven by the top FSM.

Test Plan:
- Reset mid-SHIFT of a WR_ADDR frame -> SS_n=1, MOSI=0, busy=0, req_ready=1 in the reset cycle; no rsp_valid afterwards.
- Write addr=8'hA5, wdata=8'h3C -> MOSI frame 1 = 0,00_10100101; frame 2 = 0,01_00111100; SS_n high exactly 1 cycle between frames; rsp_valid at cycle 25 after accept with rsp_rdata=0.
- Read addr=8'h0F, RAM model returns 8'hC3 on MISO starting RD_LATENCY=2 cycles after last MOSI bit -> frames 1,10_00001111 and 1,11_00000000; rsp_rdata=8'hC3 with rsp_valid.
- Back-to-back: req_valid held high with two writes -> second accepted only on the cycle after DONE; req_ready=0 throughout the first transaction.
- GAP_CYCLES=3 build, single write -> SS_n high 3 cycles between frames; rsp_valid at cycle 29 after accept.
- With SPI_MASTER_ADDR_CACHE_EN: write addr 8'h10 twice -> second transaction sends only the WR_DATA frame; then a read of 8'h10 still sends RD_ADDR first.
